z16_mem_arbiter: RTL and testbench
==================================

# z16_mem_arbiter

Arbiter that shares one single-port synchronous 16-bit memory between the Z16 CPU's two requesters: instruction fetch (F) and load/store data access (D). It sits between the CPU core and the unified memory macro. It grants at most one access per cycle with round-robin fairness under contention, and routes the one-cycle-latency read data back to the correct requester. It also keeps a saturating contention counter for performance analysis.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width
- CNT_W, 16, width of contention counter

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_f_req  in  1  fetch request (read only)
- i_f_addr  in  AW  fetch byte address
- o_f_gnt  out  1  fetch granted this cycle
- o_f_rvalid  out  1  fetch read data valid
- o_f_rdata  out  DW  fetch read data
- i_d_req  in  1  data request
- i_d_we  in  1  1 = store, 0 = load
- i_d_addr  in  AW  data byte address
- i_d_wdata  in  DW  store data
- o_d_gnt  out  1  data granted this cycle
- o_d_rvalid  out  1  load data valid
- o_d_rdata  out  DW  load data
- o_mem_en  out  1  memory access this cycle
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  AW  memory address
- o_mem_wdata  out  DW  memory write data
- i_mem_rdata  in  DW  memory read data, valid the cycle after a read
- o_contention_cnt  out  CNT_W  cycles with both requests asserted, saturating

## Operation
- Requesters hold req and payload stable until they see gnt high in the same cycle. Deassertion without a grant is legal (for example on a flush).
- Grant is combinational from the current requests and the registered priority bit `prio` (0 = D preferred, 1 = F preferred):
  - Only one requester active: that requester is granted.
  - Both active: the requester selected by `prio` is granted.
  - Neither active: o_mem_en = 0.
- Priority update (registered): after a contended grant, `prio` points to the loser. Uncontended grants leave `prio` unchanged.
- Memory drive is combinational from the granted port:
  - o_mem_en = o_f_gnt | o_d_gnt.
  - o_mem_we = o_d_gnt & i_d_we.
  - o_mem_addr and o_mem_wdata come from the granted port. They are 0 when idle.
- Response tracking uses registered tags `resp_f` and `resp_d`:
  - `resp_f` <= o_f_gnt.
  - `resp_d` <= o_d_gnt & ~i_d_we.
- Response outputs:
  - o_f_rvalid = resp_f, and o_d_rvalid = resp_d.
  - o_x_rdata = i_mem_rdata when that port's rvalid is high, else 0.
- Stores produce no rvalid. The grant is the store's completion.
- Contention counter: increments in every cycle with i_f_req & i_d_req. It saturates at 2^CNT_W−1 and never wraps.
- The CPU stall convention is req & ~gnt. The arbiter itself has no stall output.

## Timing
- Cycle N: req, grant, and the memory command are issued together.
- Cycle N+1: the read data response appears.
- Full throughput: one access per cycle, back-to-back, with no bubble between a store and a following load.
- A read granted in cycle N and a new grant in cycle N+1 coexist: the response for N and the command for N+1 occupy the same cycle.
- Reset values:
  - `prio` = 0 (D preferred).
  - resp_f = resp_d = 0.
  - o_contention_cnt = 0.
  - All rvalid outputs are 0 in the first cycle after reset.
  - Combinational grants are forced to 0 while i_rst is high. o_mem_en, o_mem_we, o_mem_addr and o_mem_wdata are therefore 0 during reset.
- Reset mid-operation: a read granted in the cycle before reset asserts produces no rvalid. Its response tag is cleared and its data is discarded.
- Simultaneous contended requests every cycle: grants strictly alternate D, F, D, F…, starting from the current `prio`.
- Counter at saturation: it holds its value while contention continues.

## Test plan
- Reset then idle: all outputs are 0 and o_mem_en stays 0 for 5 cycles.
- F-only streak: fetches at addresses 0x0000, 0x0002 and 0x0004 are granted on consecutive cycles. o_f_rvalid follows one cycle later with the memory contents 0x1234, 0x5678 and 0x9ABC.
- Contention from reset:
  - Setup: D load at 0x0100 and F fetch at 0x0010, both held.
  - Cycle 0: D is granted.
  - Cycle 1: F is granted.
  - Rvalid: o_d_rvalid in cycle 1 and o_f_rvalid in cycle 2.
  - Counter: o_contention_cnt = 1.
- Store then load to the same address:
  - Cycle 0: D store of 0xBEEF to 0x0200 gets gnt, o_mem_we = 1 and no rvalid.
  - Cycle 1: D load from 0x0200 returns 0xBEEF in cycle 2.
- Sustained contention for 6 cycles: grants alternate D, F, D, F, D, F and each port gets 3. With CNT_W = 2, the counter saturates at 3.
- Reset asserted the cycle after a granted F read: no o_f_rvalid follows, and `prio` returns to D-preferred.

Source files
------------

// File: rtl/z16_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between
// Z16 instruction fetch (F) and load/store (D), with one-cycle read return.
module z16_mem_arbiter #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_f_req,
  input  logic [AW-1:0]    i_f_addr,
  output logic             o_f_gnt,
  output logic             o_f_rvalid,
  output logic [DW-1:0]    o_f_rdata,
  input  logic             i_d_req,
  input  logic             i_d_we,
  input  logic [AW-1:0]    i_d_addr,
  input  logic [DW-1:0]    i_d_wdata,
  output logic             o_d_gnt,
  output logic             o_d_rvalid,
  output logic [DW-1:0]    o_d_rdata,
  output logic             o_mem_en,
  output logic             o_mem_we,
  output logic [AW-1:0]    o_mem_addr,
  output logic [DW-1:0]    o_mem_wdata,
  input  logic [DW-1:0]    i_mem_rdata,
  output logic [CNT_W-1:0] o_contention_cnt
);

  typedef enum logic {PRIO_D = 1'b0, PRIO_F = 1'b1} prio_t;

  prio_t            prio, prio_next;
  logic             contend;
  logic             f_gnt, d_gnt;
  logic             resp_f_p1, resp_d_p1;
  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  assign contend = i_f_req & i_d_req;

  // Stage p0: grant decision and memory command, all combinational
  always_comb begin
    f_gnt     = 1'b0;
    d_gnt     = 1'b0;
    prio_next = prio;
    if (!i_rst) begin
      if (contend) begin
        // Winner is chosen by prio; prio then points at the loser
        if (prio == PRIO_F) begin
          f_gnt     = 1'b1;
          prio_next = PRIO_D;
        end else begin
          d_gnt     = 1'b1;
          prio_next = PRIO_F;
        end
      end else begin
        f_gnt = i_f_req;
        d_gnt = i_d_req;
      end
    end
  end

  always_comb begin
    o_mem_en    = f_gnt | d_gnt;
    o_mem_we    = d_gnt & i_d_we;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (d_gnt) begin
      o_mem_addr  = i_d_addr;
      o_mem_wdata = i_d_wdata;
    end else if (f_gnt) begin
      o_mem_addr  = i_f_addr;
    end
  end

  assign o_f_gnt = f_gnt;
  assign o_d_gnt = d_gnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prio      <= PRIO_D;
      resp_f_p1 <= 1'b0;
      resp_d_p1 <= 1'b0;
      cnt       <= '0;
    end else begin
      prio      <= prio_next;
      resp_f_p1 <= f_gnt;
      resp_d_p1 <= d_gnt & ~i_d_we;
      if (contend) cnt <= sat_inc(cnt);
    end
  end

  // Stage p1: read return; a tag still set while reset is high is discarded
  assign o_f_rvalid       = resp_f_p1 & ~i_rst;
  assign o_d_rvalid       = resp_d_p1 & ~i_rst;
  assign o_f_rdata        = o_f_rvalid ? i_mem_rdata : '0;
  assign o_d_rdata        = o_d_rvalid ? i_mem_rdata : '0;
  assign o_contention_cnt = cnt;

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Directed bench for z16_mem_arbiter with a small synchronous memory model.
module tb_z16_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             f_req, d_req, d_we;
  logic [AW-1:0]    f_addr, d_addr;
  logic [DW-1:0]    d_wdata;
  logic             f_gnt, f_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0]    f_rdata, d_rdata;
  logic             mem_en, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata, mem_rdata;
  logic [CNT_W-1:0] cnt;

  logic [DW-1:0]    mem [0:1023];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  z16_mem_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt),
    .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_contention_cnt(cnt)
  );

  // Single-port synchronous memory, word-indexed by byte address
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[10:1]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[10:1]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic dr,
                       input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    @(negedge clk);
    f_req = fr; f_addr = fa; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[0]     = 16'h1234;
    mem[1]     = 16'h5678;
    mem[2]     = 16'h9ABC;
    mem[8]     = 16'h1111;  // 0x0010
    mem[16'h80] = 16'h00AA; // 0x0100
    mem_rdata = '0;
    rst = 1'b1;
    f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

    // Reset: grants and memory command forced off even with requests up
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    drive(1, 16'h0004, 1, 1, 16'h0006, 16'hFFFF);
    chk("rst_f_gnt", {31'b0, f_gnt}, 0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 0);
    chk("rst_mem_en", {31'b0, mem_en}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 0);
    chk("rst_mem_wdata", {16'b0, mem_wdata}, 0);
    chk("rst_cnt", {30'b0, cnt}, 0);
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    rst = 1'b0;

    // Idle for 5 cycles
    for (int k = 0; k < 5; k++) begin
      drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
      chk("idle_mem_en", {31'b0, mem_en}, 0);
      chk("idle_rvalid", {30'b0, f_rvalid, d_rvalid}, 0);
      chk("idle_rdata", {f_rdata, d_rdata}, 0);
      chk("idle_cnt", {30'b0, cnt}, 0);
    end

    // F-only streak
    drive(1, 16'h0000, 0, 0, 16'h0, 16'h0);
    chk("f0_gnt", {30'b0, f_gnt, d_gnt}, 32'h2);
    chk("f0_mem", {14'b0, mem_en, mem_we, mem_addr}, {14'b0, 2'b10, 16'h0000});
    chk("f0_rvalid", {31'b0, f_rvalid}, 0);
    drive(1, 16'h0002, 0, 0, 16'h0, 16'h0);
    chk("f1_gnt", {31'b0, f_gnt}, 1);
    chk("f1_addr", {16'b0, mem_addr}, 32'h0002);
    chk("f1_rdata", {15'b0, f_rvalid, f_rdata}, {15'b0, 1'b1, 16'h1234});
    drive(1, 16'h0004, 0, 0, 16'h0, 16'h0);
    chk("f2_addr", {16'b0, mem_addr}, 32'h0004);
    chk("f2_rdata", {15'b0, f_rvalid, f_rdata}, {15'b0, 1'b1, 16'h5678});
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("f3_rdata", {15'b0, f_rvalid, f_rdata}, {15'b0, 1'b1, 16'h9ABC});
    chk("f3_d_side", {15'b0, d_rvalid, d_rdata}, 0);
    chk("f3_mem_en", {31'b0, mem_en}, 0);

    // Contention: D wins first (prio D), then held F
    drive(1, 16'h0010, 1, 0, 16'h0100, 16'h0);
    chk("c0_gnt", {30'b0, f_gnt, d_gnt}, 32'h1);
    chk("c0_addr", {16'b0, mem_addr}, 32'h0100);
    chk("c0_cnt", {30'b0, cnt}, 0);
    drive(1, 16'h0010, 0, 0, 16'h0, 16'h0);
    chk("c1_gnt", {30'b0, f_gnt, d_gnt}, 32'h2);
    chk("c1_addr", {16'b0, mem_addr}, 32'h0010);
    chk("c1_d_rdata", {15'b0, d_rvalid, d_rdata}, {15'b0, 1'b1, 16'h00AA});
    chk("c1_f_rvalid", {31'b0, f_rvalid}, 0);
    chk("c1_cnt", {30'b0, cnt}, 1);
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("c2_f_rdata", {15'b0, f_rvalid, f_rdata}, {15'b0, 1'b1, 16'h1111});
    chk("c2_d_rvalid", {31'b0, d_rvalid}, 0);
    chk("c2_cnt", {30'b0, cnt}, 1);

    // Store then load to the same address, back to back
    drive(0, 16'h0, 1, 1, 16'h0200, 16'hBEEF);
    chk("s0_gnt", {30'b0, f_gnt, d_gnt}, 32'h1);
    chk("s0_mem", {mem_we, 15'b0, mem_wdata}, {1'b1, 15'b0, 16'hBEEF});
    chk("s0_addr", {16'b0, mem_addr}, 32'h0200);
    drive(0, 16'h0, 1, 0, 16'h0200, 16'h0);
    chk("s1_gnt", {31'b0, d_gnt}, 1);
    chk("s1_we", {31'b0, mem_we}, 0);
    chk("s1_store_rvalid", {31'b0, d_rvalid}, 0);
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("s2_d_rdata", {15'b0, d_rvalid, d_rdata}, {15'b0, 1'b1, 16'hBEEF});

    // Sustained contention from reset: D,F,D,F,D,F and counter saturation
    rst = 1'b1;
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1, 16'h0000, 1, 0, 16'h0002, 16'h0);
      chk("sc_gnt", {30'b0, f_gnt, d_gnt}, (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("sc_cnt", {30'b0, cnt}, (k < 3) ? k : 3);
      if (k > 0)
        chk("sc_rvalid", {30'b0, f_rvalid, d_rvalid}, (k % 2 == 1) ? 32'h1 : 32'h2);
    end
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("sc_cnt_sat", {30'b0, cnt}, 3);
    chk("sc_last_f", {15'b0, f_rvalid, f_rdata}, {15'b0, 1'b1, 16'h1234});

    // Reset right after a granted F read, with prio pointing at F beforehand
    drive(1, 16'h0002, 1, 0, 16'h0004, 16'h0);
    chk("r0_gnt", {30'b0, f_gnt, d_gnt}, 32'h1);
    drive(1, 16'h0002, 0, 0, 16'h0, 16'h0);
    chk("r1_gnt", {31'b0, f_gnt}, 1);
    rst = 1'b1;
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("r2_f_rvalid", {15'b0, f_rvalid, f_rdata}, 0);
    rst = 1'b0;
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("r3_f_rvalid", {31'b0, f_rvalid}, 0);
    chk("r3_cnt", {30'b0, cnt}, 0);
    drive(1, 16'h0000, 1, 0, 16'h0002, 16'h0);
    chk("r4_prio_d", {30'b0, f_gnt, d_gnt}, 32'h1);
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
